// File: rtl/fifo_vld_rdy_param_pkg.sv
// Shared sizing helpers for the parametrised valid/ready FIFO.
// Used by the RTL and by any environment that models the FIFO depth.
package fifo_vld_rdy_param_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 12;
    localparam int DEF_AE_THRESH = 4;

    // Occupancy needs one more code than there are entries (0..DEPTH).
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_vld_rdy_param_if.sv
// Push and pop handshake bundle for the FIFO; master is the environment, slave is the FIFO.
// Carries the driver-side stability rule for a stalled push.
interface fifo_vld_rdy_param_if
    import fifo_vld_rdy_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input logic clk,
    input logic rst
);

    logic [DATA_W-1:0] data_in;
    logic              data_in_vld;
    logic              data_in_rdy;
    logic [DATA_W-1:0] data_out;
    logic              data_out_vld;
    logic              data_out_rdy;

    modport master (
        output data_in, data_in_vld, data_out_rdy,
        input  data_in_rdy, data_out, data_out_vld
    );

    modport slave (
        input  data_in, data_in_vld, data_out_rdy,
        output data_in_rdy, data_out, data_out_vld
    );

    // A stalled push request must be held, unchanged, until it is accepted.
    a_push_stable : assert property (
        @(posedge clk) disable iff (rst)
        (data_in_vld && !data_in_rdy) |=> (data_in_vld && $stable(data_in))
    );

endinterface

// File: rtl/fifo_vld_rdy_param_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
module fifo_vld_rdy_param_ram
    import fifo_vld_rdy_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy logic guarantees only written entries are ever presented.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_vld_rdy_param.sv
// Single-clock first-word-fall-through FIFO with valid/ready ports, fill level,
// registered almost-full/almost-empty flags, synchronous flush and sticky overflow flag.
module fifo_vld_rdy_param
    import fifo_vld_rdy_param_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    fifo_vld_rdy_param_if.slave       bus,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      ovf_sticky
);

    localparam int ADDR_W  = addr_w(DEPTH);
    localparam int LEVEL_W = level_w(DEPTH);

    typedef logic [ADDR_W-1:0]  ptr_t;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t DEPTH_LVL = level_t'(DEPTH);
    localparam level_t AF_LVL    = level_t'(AF_THRESH);
    localparam level_t AE_LVL    = level_t'(AE_THRESH);

    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("fifo_vld_rdy_param: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
    end
    if (DATA_W < 1) begin : g_width_chk
        $error("fifo_vld_rdy_param: DATA_W=%0d must be >= 1", DATA_W);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
        $error("fifo_vld_rdy_param: AF_THRESH=%0d outside 1..DEPTH", AF_THRESH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_chk
        $error("fifo_vld_rdy_param: AE_THRESH=%0d outside 0..DEPTH-1", AE_THRESH);
    end

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    level_t level_next;
    logic   rdy_q;
    logic   vld_q;
    logic   rst_recover;
    logic   push;
    logic   pop;

    assign push = bus.data_in_vld & rdy_q & ~flush;
    assign pop  = vld_q & bus.data_out_rdy & ~flush;

    assign bus.data_in_rdy  = rdy_q;
    assign bus.data_out_vld = vld_q;

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else if (push && !pop) begin
            level_next = level + level_t'(1);
        end else if (pop && !push) begin
            level_next = level - level_t'(1);
        end
    end

    // Flags are registered from level_next so they always agree with level.
    // rdy deliberately ignores this cycle's pop: no data_out_rdy -> data_in_rdy path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rdy_q        <= 1'b0;
            vld_q        <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            ovf_sticky   <= 1'b0;
            rst_recover  <= 1'b1;
        end else begin
            rst_recover  <= 1'b0;
            level        <= level_next;
            rdy_q        <= (level_next < DEPTH_LVL);
            vld_q        <= (level_next != '0);
            almost_full  <= (level_next >= AF_LVL);
            almost_empty <= (level_next <= AE_LVL);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                ovf_sticky <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                // The cycle right after reset always shows rdy=0 and is not an overflow.
                if (bus.data_in_vld && !rdy_q && !rst_recover) begin
                    ovf_sticky <= 1'b1;
                end
            end
        end
    end

    fifo_vld_rdy_param_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (bus.data_out)
    );

    a_level_range : assert property (@(posedge clk) disable iff (rst) level <= DEPTH_LVL);
    a_push_not_full : assert property (@(posedge clk) disable iff (rst) push |-> (level != DEPTH_LVL));
    a_pop_not_empty : assert property (@(posedge clk) disable iff (rst) pop |-> (level != '0));
    a_vld_matches : assert property (@(posedge clk) disable iff (rst) vld_q == (level != '0));

endmodule

// File: tb/tb_fifo_vld_rdy_param.sv
// Bench for fifo_vld_rdy_param: directed scenarios on a 32x16 instance and a
// randomised queue-model comparison on an 8x4 instance.
module tb_fifo_vld_rdy_param;

    localparam int B_D  = 4;
    localparam int B_AF = 3;
    localparam int B_AE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a   = 1'b1;
    logic rst_b   = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;

    logic [4:0] level_a;
    logic       af_a, ae_a, ovf_a;
    logic [2:0] level_b;
    logic       af_b, ae_b, ovf_b;

    int checks   = 0;
    int failures = 0;

    fifo_vld_rdy_param_if #(.DATA_W(32)) if_a (.clk(clk), .rst(rst_a));
    fifo_vld_rdy_param_if #(.DATA_W(8))  if_b (.clk(clk), .rst(rst_b));

    fifo_vld_rdy_param #(
        .DATA_W(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a), .bus(if_a),
        .level(level_a), .almost_full(af_a), .almost_empty(ae_a), .ovf_sticky(ovf_a)
    );

    fifo_vld_rdy_param #(
        .DATA_W(8), .DEPTH(B_D), .AF_THRESH(B_AF), .AE_THRESH(B_AE)
    ) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b), .bus(if_b),
        .level(level_b), .almost_full(af_b), .almost_empty(ae_b), .ovf_sticky(ovf_b)
    );

    // status vector order: {rdy, vld, level, almost_full, almost_empty, ovf}
    function automatic logic [9:0] stat_a();
        return {if_a.data_in_rdy, if_a.data_out_vld, level_a, af_a, ae_a, ovf_a};
    endfunction

    task automatic test_reset();
        logic [9:0] got;
        if_a.data_in = '0; if_a.data_in_vld = 1'b0; if_a.data_out_rdy = 1'b0;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        got = stat_a();
        checks++;
        if (got !== 10'b0_0_00000_0_1_0) begin
            failures++; $display("FAIL reset_state got=%b exp=%b", got, 10'b0_0_00000_0_1_0);
        end
        rst_a = 1'b0;
        checks++;
        if (if_a.data_in_rdy !== 1'b0) begin
            failures++; $display("FAIL reset_release_rdy got=%b exp=0", if_a.data_in_rdy);
        end
        @(negedge clk);
        got = stat_a();
        checks++;
        if (got !== 10'b1_0_00000_0_1_0) begin
            failures++; $display("FAIL reset_recover got=%b exp=%b", got, 10'b1_0_00000_0_1_0);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            if_a.data_in = 32'(i); if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b0;
            @(negedge clk);
            checks++;
            if (level_a !== 5'(i + 1) || af_a !== (i + 1 >= 12) || if_a.data_in_rdy !== (i + 1 < 16) ||
                if_a.data_out_vld !== 1'b1 || if_a.data_out !== 32'h0) begin
                failures++;
                $display("FAIL fill_%0d level=%0d af=%b rdy=%b vld=%b head=%h exp level=%0d af=%b rdy=%b vld=1 head=0",
                         i, level_a, af_a, if_a.data_in_rdy, if_a.data_out_vld, if_a.data_out,
                         i + 1, (i + 1 >= 12), (i + 1 < 16));
            end
        end
        if_a.data_in_vld = 1'b0;
        if_a.data_out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (if_a.data_out_vld !== 1'b1 || if_a.data_out !== 32'(i)) begin
                failures++;
                $display("FAIL drain_data_%0d vld=%b data=%h exp vld=1 data=%h", i, if_a.data_out_vld, if_a.data_out, 32'(i));
            end
            @(negedge clk);
            checks++;
            if (level_a !== 5'(15 - i) || ae_a !== (15 - i <= 4) || af_a !== (15 - i >= 12)) begin
                failures++;
                $display("FAIL drain_level_%0d level=%0d ae=%b af=%b exp level=%0d ae=%b af=%b",
                         i, level_a, ae_a, af_a, 15 - i, (15 - i <= 4), (15 - i >= 12));
            end
        end
        if_a.data_out_rdy = 1'b0;
        checks++;
        if (if_a.data_out_vld !== 1'b0) begin
            failures++; $display("FAIL drain_empty vld=%b exp=0", if_a.data_out_vld);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            if_a.data_in = 32'h100 + 32'(i); if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b0;
            @(negedge clk);
        end
        for (int j = 0; j < 20; j++) begin
            if_a.data_in = 32'h105 + 32'(j); if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b1;
            checks++;
            if (if_a.data_out !== 32'h100 + 32'(j)) begin
                failures++; $display("FAIL simul_order_%0d data=%h exp=%h", j, if_a.data_out, 32'h100 + 32'(j));
            end
            @(negedge clk);
            checks++;
            if (level_a !== 5'd5) begin
                failures++; $display("FAIL simul_level_%0d level=%0d exp=5", j, level_a);
            end
        end
        // Contents now 0x114..0x118; top up to full.
        for (int k = 0; k < 11; k++) begin
            if_a.data_in = 32'h300 + 32'(k); if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (level_a !== 5'd16 || if_a.data_in_rdy !== 1'b0 || if_a.data_out !== 32'h114) begin
            failures++;
            $display("FAIL full_state level=%0d rdy=%b head=%h exp level=16 rdy=0 head=114", level_a, if_a.data_in_rdy, if_a.data_out);
        end
        if_a.data_in = 32'hBEEF; if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (level_a !== 5'd15 || if_a.data_in_rdy !== 1'b1 || ovf_a !== 1'b1 || if_a.data_out !== 32'h115) begin
            failures++;
            $display("FAIL full_pushpop level=%0d rdy=%b ovf=%b head=%h exp level=15 rdy=1 ovf=1 head=115",
                     level_a, if_a.data_in_rdy, ovf_a, if_a.data_out);
        end
        if_a.data_out_rdy = 1'b0;
        @(negedge clk);
        if_a.data_in_vld = 1'b0;
        checks++;
        if (level_a !== 5'd16 || if_a.data_in_rdy !== 1'b0) begin
            failures++; $display("FAIL full_retry level=%0d rdy=%b exp level=16 rdy=0", level_a, if_a.data_in_rdy);
        end
    endtask

    task automatic test_flush();
        logic [9:0] got;
        if_a.data_in_vld = 1'b0; if_a.data_out_rdy = 1'b1;
        repeat (7) @(negedge clk);
        checks++;
        if (level_a !== 5'd9 || ovf_a !== 1'b1) begin
            failures++; $display("FAIL preflush level=%0d ovf=%b exp level=9 ovf=1", level_a, ovf_a);
        end
        flush_a = 1'b1; if_a.data_in = 32'h77; if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        got = stat_a();
        checks++;
        if (got !== 10'b1_0_00000_0_1_0) begin
            failures++; $display("FAIL flush_state got=%b exp=%b", got, 10'b1_0_00000_0_1_0);
        end
        if_a.data_in = 32'hA5; if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b0;
        @(negedge clk);
        if_a.data_in_vld = 1'b0;
        checks++;
        if (if_a.data_out_vld !== 1'b1 || if_a.data_out !== 32'hA5 || level_a !== 5'd1) begin
            failures++;
            $display("FAIL flush_push vld=%b data=%h level=%0d exp vld=1 data=a5 level=1", if_a.data_out_vld, if_a.data_out, level_a);
        end
        if_a.data_out_rdy = 1'b1;
        @(negedge clk);
        if_a.data_out_rdy = 1'b0;
        checks++;
        if (level_a !== 5'd0 || if_a.data_out_vld !== 1'b0) begin
            failures++; $display("FAIL flush_pop level=%0d vld=%b exp level=0 vld=0", level_a, if_a.data_out_vld);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] got;
        for (int i = 0; i < 16; i++) begin
            if_a.data_in = 32'h200 + 32'(i); if_a.data_in_vld = 1'b1; if_a.data_out_rdy = 1'b0;
            @(negedge clk);
        end
        if_a.data_in = 32'hDEAD;
        checks++;
        if (ovf_a !== 1'b0 || level_a !== 5'd16) begin
            failures++; $display("FAIL ovf_before ovf=%b level=%0d exp ovf=0 level=16", ovf_a, level_a);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ovf_a !== 1'b1 || if_a.data_in_rdy !== 1'b0 || level_a !== 5'd16 || if_a.data_out !== 32'h200) begin
                failures++;
                $display("FAIL ovf_attempt_%0d ovf=%b rdy=%b level=%0d head=%h exp ovf=1 rdy=0 level=16 head=200",
                         c, ovf_a, if_a.data_in_rdy, level_a, if_a.data_out);
            end
        end
        #2;
        rst_a = 1'b1;
        if_a.data_in_vld = 1'b0;
        #1;
        got = stat_a();
        checks++;
        if (got !== 10'b0_0_00000_0_1_0) begin
            failures++; $display("FAIL async_rst_a got=%b exp=%b", got, 10'b0_0_00000_0_1_0);
        end
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        got = stat_a();
        checks++;
        if (got !== 10'b1_0_00000_0_1_0) begin
            failures++; $display("FAIL ovf_post_rst got=%b exp=%b", got, 10'b1_0_00000_0_1_0);
        end
    endtask

    task automatic test_random();
        logic [7:0] mq[$];
        bit         m_rdy, m_ovf, m_recov, pend;
        bit         push, pop;
        logic [7:0] got, exp;
        if_b.data_in = '0; if_b.data_in_vld = 1'b0; if_b.data_out_rdy = 1'b0; flush_b = 1'b0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        mq.delete(); m_rdy = 0; m_ovf = 0; m_recov = 1; pend = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc == 3333 || cyc == 6666) begin
                if_b.data_in_vld = 1'b0; if_b.data_out_rdy = 1'b0; flush_b = 1'b0;
                #2;
                rst_b = 1'b1;
                #1;
                got = {if_b.data_in_rdy, if_b.data_out_vld, level_b, af_b, ae_b, ovf_b};
                checks++;
                if (got !== 8'b0_0_000_0_1_0) begin
                    failures++; $display("FAIL async_rst_b cyc=%0d got=%b exp=%b", cyc, got, 8'b0_0_000_0_1_0);
                end
                repeat (2) @(negedge clk);
                rst_b = 1'b0;
                mq.delete(); m_rdy = 0; m_ovf = 0; m_recov = 1; pend = 0;
            end
            exp = {m_rdy, (mq.size() != 0), 3'(mq.size()), (mq.size() >= B_AF), (mq.size() <= B_AE), m_ovf};
            got = {if_b.data_in_rdy, if_b.data_out_vld, level_b, af_b, ae_b, ovf_b};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            if (mq.size() != 0) begin
                checks++;
                if (if_b.data_out !== mq[0]) begin
                    failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, if_b.data_out, mq[0]);
                end
            end
            if (!pend) begin
                if_b.data_in_vld = ($urandom_range(0, 99) < 60);
                if_b.data_in     = 8'($urandom);
            end
            if_b.data_out_rdy = ($urandom_range(0, 99) < 55);
            flush_b           = ($urandom_range(0, 63) == 0);
            push = if_b.data_in_vld && m_rdy && !flush_b;
            pop  = (mq.size() != 0) && if_b.data_out_rdy && !flush_b;
            pend = if_b.data_in_vld && !m_rdy;
            if (flush_b) begin
                mq.delete();
                m_ovf = 0;
            end else begin
                if (if_b.data_in_vld && !m_rdy && !m_recov) m_ovf = 1;
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(if_b.data_in);
            end
            m_rdy   = (mq.size() < B_D);
            m_recov = 0;
            @(negedge clk);
        end
        if_b.data_in_vld = 1'b0; if_b.data_out_rdy = 1'b0; flush_b = 1'b0;
    endtask

    initial begin
        if_b.data_in = '0; if_b.data_in_vld = 1'b0; if_b.data_out_rdy = 1'b0;
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_flush();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
